// File: rtl/divider_seq.sv
// divider_seq: restoring shift-subtract divider, one quotient bit per clock.
// Define DIVSEQ_SIGNED_EN to add the signed_op port and a sign fix-up cycle.
module divider_seq #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
`ifdef DIVSEQ_SIGNED_EN
   input  logic         signed_op,
`endif
   output logic         busy,
   output logic         done,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         div_by_zero
);

   localparam int CW = (N > 2) ? $clog2(N) : 1;

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] RUN  = 3'd1;
   localparam logic [2:0] ZERO = 3'd2;
   localparam logic [2:0] DONE = 3'd4;
`ifdef DIVSEQ_SIGNED_EN
   localparam logic [2:0] FIX  = 3'd3;
`endif

   logic [2:0]    state;
   logic [N-1:0]  r;
   logic [N-1:0]  q;
   logic [N-1:0]  b;
   logic [CW-1:0] cnt;

   logic          accept;
   logic [N:0]    sh;
   logic [N+1:0]  diff;
   logic          ge;
   logic [N-1:0]  r_nx;
   logic [N-1:0]  q_nx;
   logic [N-1:0]  a_mag;
   logic [N-1:0]  b_mag;
   logic          unused_diff;

`ifdef DIVSEQ_SIGNED_EN
   logic          sop;
   logic          neg_q;
   logic          neg_r;
   logic          a_neg;
   logic          b_neg;

   assign a_neg = signed_op & dividend[N-1];
   assign b_neg = signed_op & divisor[N-1];
   assign a_mag = a_neg ? -dividend : dividend;
   assign b_mag = b_neg ? -divisor : divisor;
`else
   assign a_mag = dividend;
   assign b_mag = divisor;
`endif

   assign accept = start & ((state == IDLE) | (state == DONE));

   // R stays below the divisor, so after a successful subtract diff[N] is 0
   always_comb begin
      sh   = {r, q[N-1]};
      diff = {1'b0, sh} - {2'b00, b};
      ge   = ~diff[N+1];
      r_nx = ge ? diff[N-1:0] : sh[N-1:0];
      q_nx = {q[N-2:0], ge};
   end

   assign unused_diff = diff[N];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         r           <= '0;
         q           <= '0;
         b           <= '0;
         cnt         <= '0;
`ifdef DIVSEQ_SIGNED_EN
         sop         <= 1'b0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         if (accept) begin
            r <= '0;
`ifdef DIVSEQ_SIGNED_EN
            sop   <= signed_op;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
`endif
            if (divisor == '0) begin
               state <= ZERO;
               q     <= dividend;
               b     <= '0;
            end else begin
               state <= RUN;
               busy  <= 1'b1;
               q     <= a_mag;
               b     <= b_mag;
               cnt   <= CW'(N - 1);
            end
         end else begin
            unique case (state)
               RUN: begin
                  r   <= r_nx;
                  q   <= q_nx;
                  cnt <= cnt - 1'b1;
                  if (cnt == '0) begin
`ifdef DIVSEQ_SIGNED_EN
                     if (sop) begin
                        state <= FIX;
                     end else begin
                        state       <= DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        quotient    <= q_nx;
                        remainder   <= r_nx;
                        div_by_zero <= 1'b0;
                     end
`else
                     state       <= DONE;
                     busy        <= 1'b0;
                     done        <= 1'b1;
                     quotient    <= q_nx;
                     remainder   <= r_nx;
                     div_by_zero <= 1'b0;
`endif
                  end
               end
`ifdef DIVSEQ_SIGNED_EN
               FIX: begin
                  state       <= DONE;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  quotient    <= neg_q ? -q : q;
                  remainder   <= neg_r ? -r : r;
                  div_by_zero <= 1'b0;
               end
`endif
               // q holds the raw dividend here, passed through unmodified
               ZERO: begin
                  state       <= DONE;
                  done        <= 1'b1;
                  quotient    <= '1;
                  remainder   <= q;
                  div_by_zero <= 1'b1;
               end
               DONE:    state <= IDLE;
               IDLE:    state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_divider_seq.sv
// tb_divider_seq: vector table, random model check and handshake corners.
// Signed cases are compiled in only with DIVSEQ_SIGNED_EN.
`timescale 1ns/1ps
module tb_divider_seq;

   localparam int N = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [N-1:0]  dividend = '0;
   logic [N-1:0]  divisor = '0;
   logic          signed_op = 1'b0;
   logic          busy;
   logic          done;
   logic [N-1:0]  quotient;
   logic [N-1:0]  remainder;
   logic          div_by_zero;

   int ncmp = 0;
   int nfail = 0;

   divider_seq #(.N(N)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
`ifdef DIVSEQ_SIGNED_EN
      .signed_op   (signed_op),
`endif
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      logic [31:0] eq;
      logic [31:0] er;
      logic        ez;
      int          el;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic model(input logic [31:0] a, input logic [31:0] b,
                        input logic s, output logic [31:0] q,
                        output logic [31:0] r, output logic z,
                        output int lat);
      longint sa, sb, sq, sr;
      if (b == 0) begin
         q = '1; r = a; z = 1'b1; lat = 1;
      end else if (s) begin
         sa = $signed(a);
         sb = $signed(b);
         sq = sa / sb;
         sr = sa % sb;
         q = sq[31:0]; r = sr[31:0]; z = 1'b0; lat = N + 1;
      end else begin
         q = a / b; r = a % b; z = 1'b0; lat = N;
      end
   endtask

   task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                          input logic s, output logic [31:0] q,
                          output logic [31:0] r, output logic z,
                          output int lat, output logic sawbusy);
      @(negedge clk);
      dividend = a; divisor = b; signed_op = s; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      sawbusy = busy;
      while (!done && lat < 200) begin
         @(negedge clk);
         lat++;
         sawbusy |= busy;
      end
      q = quotient; r = remainder; z = div_by_zero;
   endtask

   task automatic check_vec(input string name, input vec_t v);
      logic [31:0] q, r;
      logic        z, sb;
      int          lat;
      run_div(v.a, v.b, v.s, q, r, z, lat, sb);
      chk({name, ".quotient"}, 64'(q), 64'(v.eq));
      chk({name, ".remainder"}, 64'(r), 64'(v.er));
      chk({name, ".dbz"}, 64'(z), 64'(v.ez));
      chk({name, ".latency"}, 64'(lat), 64'(v.el));
      chk({name, ".busy_seen"}, 64'(sb), 64'(v.b != 0));
   endtask

   task automatic check_model(input string name, input logic [31:0] a,
                              input logic [31:0] b, input logic s);
      vec_t v;
      v.a = a; v.b = b; v.s = s;
      model(a, b, s, v.eq, v.er, v.ez, v.el);
      check_vec(name, v);
   endtask

   initial begin
      logic [31:0] ra, rb;
      logic        rs;
      int          n;
      logic        sawdone;

      tbl.push_back('{32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 32});
      tbl.push_back('{32'd5, 32'd0, 1'b0, 32'hFFFFFFFF, 32'd5, 1'b1, 1});
      tbl.push_back('{32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'd0, 1'b0, 32});
      tbl.push_back('{32'd0, 32'd5, 1'b0, 32'd0, 32'd0, 1'b0, 32});
      tbl.push_back('{32'd7, 32'd7, 1'b0, 32'd1, 32'd0, 1'b0, 32});
      tbl.push_back('{32'd6, 32'd7, 1'b0, 32'd0, 32'd6, 1'b0, 32});
      tbl.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd1, 32'd0, 1'b0, 32});
      tbl.push_back('{32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0, 32'd0, 32'hFFFFFFFE, 1'b0, 32});
      tbl.push_back('{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0, 32'h80000000, 1'b0, 32});
      tbl.push_back('{32'h12345678, 32'h10, 1'b0, 32'h01234567, 32'd8, 1'b0, 32});
`ifdef DIVSEQ_SIGNED_EN
      tbl.push_back('{32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33});
      tbl.push_back('{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 1'b0, 33});
      tbl.push_back('{32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1, 1'b0, 33});
      tbl.push_back('{32'hFFFFFFF9, 32'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, 1});
`endif

      // reset state
      #1;
      chk("reset.busy", 64'(busy), 64'd0);
      chk("reset.done", 64'(done), 64'd0);
      chk("reset.dbz", 64'(div_by_zero), 64'd0);
      chk("reset.quotient", 64'(quotient), 64'd0);
      chk("reset.remainder", 64'(remainder), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i]) check_vec($sformatf("vec%0d", i), tbl[i]);

      for (int i = 0; i < 150; i++) begin
         ra = $urandom;
         rb = $urandom;
         rs = 1'b0;
         if (i % 8 == 0) rb = 0;
         else if (i % 3 == 1) rb = $urandom_range(1, 255);
         if (i % 5 == 2) ra = $urandom_range(0, 1000);
`ifdef DIVSEQ_SIGNED_EN
         rs = 1'($urandom_range(0, 1));
`endif
         check_model($sformatf("rand%0d", i), ra, rb, rs);
      end

      // extra starts during RUN are ignored
      @(negedge clk);
      dividend = 32'hFFFFFFFF; divisor = 32'd1; signed_op = 1'b0;
      start = 1'b1;
      @(negedge clk);
      n = 0;
      while (!done && n < 200) begin
         dividend = $urandom; divisor = $urandom | 32'd1;
         @(negedge clk);
         n++;
      end
      chk("repulse.latency", 64'(n), 64'(N));
      chk("repulse.quotient", 64'(quotient), 64'hFFFFFFFF);
      chk("repulse.remainder", 64'(remainder), 64'd0);

      // accept in the DONE cycle
      dividend = 32'd1000; divisor = 32'd10; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("b2b.done_low", 64'(done), 64'd0);
      chk("b2b.busy_high", 64'(busy), 64'd1);
      n = 0;
      while (!done && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("b2b.latency", 64'(n), 64'(N));
      chk("b2b.quotient", 64'(quotient), 64'd100);
      chk("b2b.remainder", 64'(remainder), 64'd0);

      // reset during iteration 10
      @(negedge clk);
      dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst.busy", 64'(busy), 64'd0);
      chk("midrst.done", 64'(done), 64'd0);
      chk("midrst.quotient", 64'(quotient), 64'd0);
      chk("midrst.remainder", 64'(remainder), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      sawdone = 1'b0;
      repeat (40) begin
         @(negedge clk);
         sawdone |= done;
      end
      chk("midrst.no_done", 64'(sawdone), 64'd0);
      check_model("midrst.redo", 32'd1000, 32'd3, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
